// File: rtl/hex_display_arbiter_if.sv
// Request/value bus between the two display requesters and hex_display_arbiter,
// plus the registered grant, busy and segment outputs going to HEX0-HEX7.
interface hex_display_arbiter_if;
   logic [1:0]  i_req;
   logic [31:0] i_value0;
   logic [31:0] i_value1;
   logic [7:0]  i_blank0;
   logic [7:0]  i_blank1;
   logic [1:0]  o_gnt;
   logic        o_busy;
   logic [6:0]  o_hex0;
   logic [6:0]  o_hex1;
   logic [6:0]  o_hex2;
   logic [6:0]  o_hex3;
   logic [6:0]  o_hex4;
   logic [6:0]  o_hex5;
   logic [6:0]  o_hex6;
   logic [6:0]  o_hex7;

   modport master (
      output i_req, i_value0, i_value1, i_blank0, i_blank1,
      input  o_gnt, o_busy,
      input  o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_hex6, o_hex7
   );

   modport slave (
      input  i_req, i_value0, i_value1, i_blank0, i_blank1,
      output o_gnt, o_busy,
      output o_hex0, o_hex1, o_hex2, o_hex3, o_hex4, o_hex5, o_hex6, o_hex7
   );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the eight-digit seven-segment bank between two
// requesters; the owner's value is scanned through one shared decoder.
module SevenHexDecoder (
   input  logic [3:0] digit,
   output logic [6:0] segments
);
   // Active-low segments, bit 0 = top, bit 6 = middle.
   always_comb begin
      case (digit)
         4'h0:    segments = 7'h40;
         4'h1:    segments = 7'h79;
         4'h2:    segments = 7'h24;
         4'h3:    segments = 7'h30;
         4'h4:    segments = 7'h19;
         4'h5:    segments = 7'h12;
         4'h6:    segments = 7'h02;
         4'h7:    segments = 7'h58;
         4'h8:    segments = 7'h00;
         4'h9:    segments = 7'h10;
         4'hA:    segments = 7'h08;
         4'hB:    segments = 7'h03;
         4'hC:    segments = 7'h46;
         4'hD:    segments = 7'h21;
         4'hE:    segments = 7'h06;
         default: segments = 7'h0E;
      endcase
   end
endmodule

module hex_display_arbiter #(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   hex_display_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SCAN, HOLD} state_t;

   state_t           state;
   logic             last;
   logic             owner;
   logic [1:0]       gnt;
   logic             busy;
   logic [31:0]      value_q;
   logic [7:0]       blank_q;
   logic [2:0]       idx;
   logic [CNT_W-1:0] hold_cnt;
   logic [6:0]       hex_q [8];
   logic [3:0]       digit;
   logic [6:0]       seg;
   logic             pick;
   logic             next_owner;

   assign pick       = (bus.i_req == 2'b11) ? ~last : bus.i_req[1];
   assign next_owner = bus.i_req[~owner] ? ~owner : owner;
   assign digit      = value_q[{idx, 2'b00} +: 4];

   SevenHexDecoder decoder (
      .digit    (digit),
      .segments (seg)
   );

   // Expiry fires when the counter reaches HOLD_CYCLES, so HOLD lasts
   // HOLD_CYCLES+1 cycles and a full turn is 10+HOLD_CYCLES cycles.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= IDLE;
         last     <= 1'b1;
         owner    <= 1'b0;
         gnt      <= 2'b00;
         busy     <= 1'b0;
         value_q  <= '0;
         blank_q  <= '0;
         idx      <= '0;
         hold_cnt <= '0;
         for (int k = 0; k < 8; k++) hex_q[k] <= 7'h7F;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_req != 2'b00) begin
                  owner <= pick;
                  last  <= pick;
                  gnt   <= {pick, ~pick};
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               value_q <= owner ? bus.i_value1 : bus.i_value0;
               blank_q <= owner ? bus.i_blank1 : bus.i_blank0;
               idx     <= '0;
               state   <= SCAN;
            end
            SCAN: begin
               hex_q[idx] <= blank_q[idx] ? 7'h7F : seg;
               idx        <= idx + 3'd1;
               if (idx == 3'd7) begin
                  busy     <= 1'b0;
                  hold_cnt <= '0;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (!bus.i_req[owner]) begin
                  gnt   <= 2'b00;
                  state <= IDLE;
               end else if (hold_cnt == CNT_W'(HOLD_CYCLES)) begin
                  owner <= next_owner;
                  last  <= next_owner;
                  gnt   <= {next_owner, ~next_owner};
                  busy  <= 1'b1;
                  state <= LOAD;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_gnt  = gnt;
   assign bus.o_busy = busy;
   assign bus.o_hex0 = hex_q[0];
   assign bus.o_hex1 = hex_q[1];
   assign bus.o_hex2 = hex_q[2];
   assign bus.o_hex3 = hex_q[3];
   assign bus.o_hex4 = hex_q[4];
   assign bus.o_hex5 = hex_q[5];
   assign bus.o_hex6 = hex_q[6];
   assign bus.o_hex7 = hex_q[7];
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter: expected grant and display-complete
// events are queued by the stimulus and popped by a negedge monitor.
module tb_hex_display_arbiter;
   localparam logic [63:0] DARK      = 64'h7F7F_7F7F_7F7F_7F7F;
   localparam logic [63:0] V01234567 = 64'h4079_2430_1912_0258;
   localparam logic [63:0] VDEADBEEF = 64'h2106_0821_0306_060E;
   localparam logic [63:0] V89ABCDEF = 64'h0010_0803_4621_060E;
   localparam logic [63:0] V89AB_F0  = 64'h7F7F_7F7F_4621_060E;
   localparam logic [63:0] VZERO_F0  = 64'h7F7F_7F7F_4040_4040;

   typedef struct {
      bit          isGrant;
      logic [1:0]  gnt;
      int          gap;
      logic [63:0] hex;
      string       name;
   } expEvent_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   passes;
   int   lastGrantCyc;
   logic [1:0] prevGnt;
   logic       prevBusy;
   expEvent_t  expQ[$];

   hex_display_arbiter_if bus();

   hex_display_arbiter #(.HOLD_CYCLES(4), .CNT_W(4)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [63:0] hexNow();
      return {1'b0, bus.o_hex7, 1'b0, bus.o_hex6, 1'b0, bus.o_hex5, 1'b0, bus.o_hex4,
              1'b0, bus.o_hex3, 1'b0, bus.o_hex2, 1'b0, bus.o_hex1, 1'b0, bus.o_hex0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] expHex,
                              input logic [1:0] expGnt, input logic expBusy);
      check({name, "_hex"}, hexNow(), expHex);
      check({name, "_gnt"}, 64'(bus.o_gnt), 64'(expGnt));
      check({name, "_busy"}, 64'(bus.o_busy), 64'(expBusy));
   endtask

   task automatic applyStimulus(input logic [1:0] req, input logic [31:0] v0, input logic [31:0] v1,
                                input logic [7:0] b0, input logic [7:0] b1);
      bus.i_req    = req;
      bus.i_value0 = v0;
      bus.i_value1 = v1;
      bus.i_blank0 = b0;
      bus.i_blank1 = b1;
   endtask

   task automatic pushGrant(input string name, input logic [1:0] gnt, input int gap);
      expEvent_t e;
      e.isGrant = 1'b1; e.gnt = gnt; e.gap = gap; e.hex = '0; e.name = name;
      expQ.push_back(e);
   endtask

   task automatic pushDisplay(input string name, input logic [1:0] gnt, input logic [63:0] hex,
                              input int gap);
      expEvent_t e;
      e.isGrant = 1'b0; e.gnt = gnt; e.gap = gap; e.hex = hex; e.name = name;
      expQ.push_back(e);
   endtask

   task automatic popCheck(input bit isGrant);
      expEvent_t e;
      if (expQ.size() == 0) begin
         checks++;
         $display("[TB] FAIL unexpected_event: got %s event (gnt %b) at cycle %0d, want none",
                  isGrant ? "grant" : "display", bus.o_gnt, cyc);
         return;
      end
      e = expQ.pop_front();
      check({e.name, "_kind"}, 64'(isGrant), 64'(e.isGrant));
      check({e.name, "_gnt"}, 64'(bus.o_gnt), 64'(e.gnt));
      if (!e.isGrant) check({e.name, "_hex"}, hexNow(), e.hex);
      if (e.gap >= 0) check({e.name, "_gap"}, 64'(cyc - lastGrantCyc), 64'(e.gap));
      if (isGrant) lastGrantCyc = cyc;
   endtask

   // Monitor: a new non-zero grant or a falling busy is a DUT event.
   initial begin
      prevGnt  = 2'b00;
      prevBusy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.o_gnt != prevGnt && bus.o_gnt != 2'b00) popCheck(1'b1);
            if (prevBusy && !bus.o_busy) popCheck(1'b0);
         end
         prevGnt  = bus.o_gnt;
         prevBusy = bus.o_busy;
      end
   end

   task automatic waitQueueEmpty(input string name, input int budget);
      int n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (expQ.size() != 0) begin
         checks++;
         $display("[TB] FAIL %s_timeout: got %0d pending events, want 0", name, expQ.size());
         expQ.delete();
      end
   endtask

   task automatic waitGrant(input string name);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (bus.o_gnt == 2'b00 && n < 20);
      if (bus.o_gnt == 2'b00) begin
         checks++;
         $display("[TB] FAIL %s_grant_timeout: got gnt 00, want a grant", name);
      end
   endtask

   task automatic applyReset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", DARK, 2'b00, 1'b0);
      rst = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0; passes = 0; cyc = 0; lastGrantCyc = 0;
      rst = 1'b1;
      applyStimulus(2'b00, '0, '0, '0, '0);
      @(posedge clk); #1;
      applyReset();
      idleCycles(3);
      checkOutput("idle_no_req", DARK, 2'b00, 1'b0);

      // Single requester 0, full scan.
      pushGrant("r0_grant", 2'b01, -1);
      pushDisplay("r0_display", 2'b01, V01234567, 9);
      applyStimulus(2'b01, 32'h0123_4567, 32'h0, 8'h00, 8'h00);
      waitQueueEmpty("r0", 30);
      applyStimulus(2'b00, 32'h0123_4567, 32'h0, 8'h00, 8'h00);
      idleCycles(3);
      checkOutput("r0_retained", V01234567, 2'b00, 1'b0);

      // Blank mask, value change in HOLD, then same-owner refresh.
      pushGrant("blank_grant", 2'b01, -1);
      pushDisplay("blank_display", 2'b01, V89AB_F0, 9);
      applyStimulus(2'b01, 32'h89AB_CDEF, 32'h0, 8'hF0, 8'h00);
      waitQueueEmpty("blank", 30);
      pushDisplay("refresh_display", 2'b01, VZERO_F0, 23);
      applyStimulus(2'b01, 32'h0000_0000, 32'h0, 8'hF0, 8'h00);
      idleCycles(1);
      checkOutput("hold_value_change", V89AB_F0, 2'b01, 1'b0);
      waitQueueEmpty("refresh", 40);
      applyStimulus(2'b00, 32'h0, 32'h0, 8'h00, 8'h00);
      idleCycles(3);

      // Round robin with both requesting from reset.
      applyReset();
      pushGrant("rr_grant0", 2'b01, -1);
      pushDisplay("rr_display0", 2'b01, V01234567, 9);
      pushGrant("rr_grant1", 2'b10, 14);
      pushDisplay("rr_display1", 2'b10, VDEADBEEF, 9);
      pushGrant("rr_grant2", 2'b01, 14);
      pushDisplay("rr_display2", 2'b01, V01234567, 9);
      applyStimulus(2'b11, 32'h0123_4567, 32'hDEAD_BEEF, 8'h00, 8'h00);
      waitQueueEmpty("rr", 80);
      applyStimulus(2'b00, 32'h0123_4567, 32'hDEAD_BEEF, 8'h00, 8'h00);
      idleCycles(3);

      // Owner drops in the expiry cycle: drop wins, other granted via IDLE.
      applyReset();
      pushGrant("drop_grant0", 2'b01, -1);
      pushDisplay("drop_display0", 2'b01, V89ABCDEF, 9);
      pushGrant("drop_grant1", 2'b10, 15);
      pushDisplay("drop_display1", 2'b10, VDEADBEEF, 9);
      applyStimulus(2'b11, 32'h89AB_CDEF, 32'hDEAD_BEEF, 8'h00, 8'h00);
      waitGrant("drop");
      repeat (13) @(posedge clk);
      #1;
      applyStimulus(2'b10, 32'h89AB_CDEF, 32'hDEAD_BEEF, 8'h00, 8'h00);
      idleCycles(1);
      checkOutput("drop_idle", V89ABCDEF, 2'b00, 1'b0);
      waitQueueEmpty("drop", 30);
      applyStimulus(2'b00, 32'h89AB_CDEF, 32'hDEAD_BEEF, 8'h00, 8'h00);
      idleCycles(3);

      // Reset in the middle of a scan, then tie after release.
      pushGrant("abort_grant", 2'b01, -1);
      applyStimulus(2'b01, 32'h0123_4567, 32'hDEAD_BEEF, 8'h00, 8'h00);
      waitGrant("abort");
      repeat (4) @(posedge clk);
      #1;
      check("abort_partial_hex", 64'({bus.o_hex2, bus.o_hex1, bus.o_hex0}),
            64'({7'h12, 7'h02, 7'h58}));
      rst = 1'b1;
      idleCycles(1);
      checkOutput("abort_reset", DARK, 2'b00, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      waitQueueEmpty("abort", 5);
      pushGrant("tie_grant", 2'b01, -1);
      pushDisplay("tie_display", 2'b01, V01234567, 9);
      applyStimulus(2'b11, 32'h0123_4567, 32'hDEAD_BEEF, 8'h00, 8'h00);
      waitQueueEmpty("tie", 30);
      applyStimulus(2'b00, 32'h0123_4567, 32'hDEAD_BEEF, 8'h00, 8'h00);
      idleCycles(5);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no completion by cycle %0d, want completion", cyc);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
